adc_capture: RTL and testbench
==============================

// Module: adc_capture
// PURPOSE
//  Receive side of the RFSoC data path: takes the 256-bit ADC AXIS stream (16 x 16-bit samples/beat)
//  from the RFSoC IP and arms on a PS command. On trigger_in it captures a programmed number of beats
//  into an internal block-RAM buffer, then drains the buffer to the PS over AXIS.
//  Sits beside the DAC driver; shares its trigger_in and the gpio-derived flush control.
// PARAMETERS
//  DEPTH_LOG2   10   buffer depth = 2**DEPTH_LOG2 beats of 256 bits
// PORTS
//  clk            in   1             single clock for all logic
//  rst            in   1             asynchronous, active-low reset
//  s_axis_tdata   in   256           ADC samples from RFSoC IP
//  s_axis_tvalid  in   1             ADC beat valid
//  s_axis_tready  out  1             constant 1 after reset (ADC stream is never stalled)
//  m_axis_tdata   out  256           captured beats to PS
//  m_axis_tvalid  out  1             drain beat valid
//  m_axis_tready  in   1             PS ready
//  m_axis_tlast   out  1             last drain beat (only with ADC_TLAST_EN)
//  arm            in   1             single-cycle arm request
//  flush          in   1             abort/clear, level (gpio adc_buffer_flush)
//  capture_len    in   DEPTH_LOG2+1  beats to capture, sampled on accepted arm
//  trigger_in     in   1             capture trigger, rising-edge sensitive
//  busy           out  1             state != IDLE
//  capture_done   out  1             1-cycle pulse when the last drain beat handshakes
// BEHAVIOUR
//  Reset: state IDLE; m_axis_tvalid, m_axis_tlast, busy, capture_done = 0; pointers/counters = 0;
//   m_axis_tdata = 0; trigger edge register = 0; s_axis_tready = 1.
//  FSM IDLE -> ARMED -> CAPTURE -> DRAIN -> IDLE.
//  IDLE: arm=1 latches len = min(capture_len, 2**DEPTH_LOG2).
//   If len==0, stay IDLE and emit no output; else go to ARMED. ADC beats are discarded.
//  ARMED: trig_q registers trigger_in every cycle. An edge is trigger_in & ~trig_q in cycle N.
//   On an edge, enter CAPTURE at N+1. The first beat written is the first valid beat from N+1 on.
//   ADC beats are discarded while in ARMED.
//  CAPTURE: each s_axis_tvalid beat is written at wr_ptr, then wr_ptr++.
//   When wr_ptr==len after a write, go to DRAIN. Beats not written are dropped.
//  DRAIN: RAM read latency 1 behind a 1-entry output register.
//   First m_axis_tvalid no later than 2 cycles after DRAIN entry.
//   tdata/tvalid are held stable while tvalid & ~tready. A new beat every cycle while tready=1.
//   On the handshake of beat index len-1: capture_done=1 for that cycle; IDLE on the next cycle.
//  Ignored: arm outside IDLE; trigger edge outside ARMED; a trigger level already high at arm
//   (it is not an edge).
//  flush=1 (any state, priority over arm/trigger) -> next cycle: IDLE, pointers 0,
//   m_axis_tvalid=0, m_axis_tlast=0, capture_done=0.
//   An in-flight drain beat is abandoned (abort semantics).
//  Simultaneous arm & flush in IDLE: flush wins, stay IDLE.
//  Reset asserted mid-operation: immediate return to reset values; buffer contents undefined.
//  Buffer never overflows: len <= depth; wr_ptr/rd_ptr are DEPTH_LOG2+1 bits wide, no wrap.
// CONFIGURATION
//  ADC_TLAST_EN defined: m_axis_tlast port exists. It is 1 exactly with the valid beat index len-1
//   and is held with tdata while stalled.
//  ADC_TLAST_EN undefined: port absent. PS counts beats via the capture_len it programmed.
// TESTING
//  1. arm, len=4, trigger edge, 6 beats D0..D5 -> m_axis emits D0..D3 in order;
//     capture_done once on D3; busy falls next cycle.
//  2. len=4, m_axis_tready toggling 1,0,0,1... -> tdata stable while stalled;
//     exactly 4 handshakes; tlast only on D3 (ADC_TLAST_EN).
//  3. trigger high before arm, stays high -> remains ARMED. Low then high -> capture starts.
//  4. flush mid-CAPTURE after 2 of 8 beats -> IDLE next cycle, tvalid 0; re-arm with len=2 captures fresh data.
//  5. capture_len=0 -> stays IDLE, no output. capture_len=2**DEPTH_LOG2+5 -> exactly 2**DEPTH_LOG2 beats out.
//  6. rst low during DRAIN -> all outputs at reset values asynchronously; s_axis_tready=1 after release.

Source files
------------

// File: rtl/adc_capture_if.sv
// AXI-Stream bundle used for both the ADC input and the PS drain output.
// The tlast signal exists only when ADC_TLAST_EN is defined.
interface adc_capture_if #(
    parameter int DATA_W = 256
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
`ifdef ADC_TLAST_EN
    logic              tlast;
    modport master (output tdata, output tvalid, output tlast, input tready);
`else
    modport master (output tdata, output tvalid, input tready);
`endif
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/adc_capture.sv
// ADC capture buffer: arm, capture a programmed number of beats after a trigger edge, then drain to the PS.
// Optional feature macro ADC_TLAST_EN adds m_axis.tlast on the final drain beat.
module adc_capture #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    adc_capture_if.slave        s_axis,
    adc_capture_if.master       m_axis,
    input  logic                i_arm,
    input  logic                i_flush,
    input  logic [DEPTH_LOG2:0] i_capture_len,
    input  logic                i_trigger_in,
    output logic                o_busy,
    output logic                o_capture_done
);
    localparam int DATA_W = 256;
    localparam int DEPTH  = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] LP_DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_CAPTURE,
        ST_DRAIN
    } state_t;

    state_t              r_state;
    logic [DEPTH_LOG2:0] r_len;
    logic [DEPTH_LOG2:0] r_wr_ptr;
    logic [DEPTH_LOG2:0] r_rd_ptr;
    logic [DEPTH_LOG2:0] r_out_cnt;
    logic                r_trig_q;
    logic                r_rd_vld;
    logic                r_out_valid;
    logic                r_out_last;
    logic [DATA_W-1:0]   r_out_data;
    logic [DATA_W-1:0]   r_rd_data;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic [DEPTH_LOG2:0] w_len_sat;
    logic [DEPTH_LOG2:0] w_wr_next;
    logic [DEPTH_LOG2:0] w_last_idx;
    logic                w_trig_edge;
    logic                w_wr_en;
    logic                w_drain;
    logic                w_out_free;
    logic                w_hs;
    logic                w_load;
    logic                w_issue;

    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        w_len_sat = i_capture_len;
        if (i_capture_len > LP_DEPTH) begin
            w_len_sat = LP_DEPTH;
        end
    end

    assign w_wr_next   = r_wr_ptr + 1'b1;
    assign w_last_idx  = r_len - 1'b1;
    assign w_trig_edge = i_trigger_in & ~r_trig_q;
    assign w_wr_en     = (r_state == ST_CAPTURE) & s_axis.tvalid & ~i_flush;
    assign w_drain     = (r_state == ST_DRAIN);

    // The RAM data register is a staging slot ahead of the output register; a read is
    // issued only when that slot will be free next cycle, which sustains one beat per cycle.
    assign w_out_free  = ~r_out_valid | m_axis.tready;
    assign w_hs        = r_out_valid & m_axis.tready;
    assign w_load      = w_drain & r_rd_vld & w_out_free;
    assign w_issue     = w_drain & (r_rd_ptr != r_len) & (~r_rd_vld | w_out_free);

    // NOTE: the buffer has no reset so it maps onto block RAM; its contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= s_axis.tdata;
        end
        if (w_issue) begin
            r_rd_data <= r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_len       <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_out_cnt   <= '0;
            r_trig_q    <= 1'b0;
            r_rd_vld    <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_trig_q <= i_trigger_in;
            if (i_flush) begin
                r_state     <= ST_IDLE;
                r_wr_ptr    <= '0;
                r_rd_ptr    <= '0;
                r_out_cnt   <= '0;
                r_rd_vld    <= 1'b0;
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (i_arm && (w_len_sat != '0)) begin
                            r_len    <= w_len_sat;
                            r_wr_ptr <= '0;
                            r_state  <= ST_ARMED;
                        end
                    end
                    ST_ARMED: begin
                        if (w_trig_edge) begin
                            r_state <= ST_CAPTURE;
                        end
                    end
                    ST_CAPTURE: begin
                        if (s_axis.tvalid) begin
                            r_wr_ptr <= w_wr_next;
                            if (w_wr_next == r_len) begin
                                r_state   <= ST_DRAIN;
                                r_rd_ptr  <= '0;
                                r_out_cnt <= '0;
                                r_rd_vld  <= 1'b0;
                            end
                        end
                    end
                    ST_DRAIN: begin
                        if (w_issue) begin
                            r_rd_ptr <= r_rd_ptr + 1'b1;
                        end
                        if (w_issue) begin
                            r_rd_vld <= 1'b1;
                        end else if (w_load) begin
                            r_rd_vld <= 1'b0;
                        end
                        if (w_load) begin
                            r_out_data  <= r_rd_data;
                            r_out_valid <= 1'b1;
                            r_out_last  <= (r_out_cnt == w_last_idx);
                            r_out_cnt   <= r_out_cnt + 1'b1;
                        end else if (w_hs) begin
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                        end
                        if (w_hs && r_out_last) begin
                            r_state     <= ST_IDLE;
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_rd_vld    <= 1'b0;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign s_axis.tready  = 1'b1;
    assign m_axis.tdata   = r_out_data;
    assign m_axis.tvalid  = r_out_valid;
`ifdef ADC_TLAST_EN
    assign m_axis.tlast   = r_out_last;
`endif
    assign o_busy         = (r_state != ST_IDLE);
    // Done must coincide with the final handshake, so it combines the registered last flag with tready.
    assign o_capture_done = w_drain & r_out_valid & r_out_last & m_axis.tready;

endmodule

// File: tb/tb_adc_capture.sv
// Self-checking bench for adc_capture: beat-queue reference model plus directed scenarios.
// Build with ADC_TLAST_EN defined to also check m_axis.tlast.
module tb_adc_capture;
    localparam int DL    = 10;
    localparam int DEPTH = 1 << DL;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        arm   = 1'b0;
    logic        flush = 1'b0;
    logic        trig  = 1'b0;
    logic [DL:0] cap_len = '0;
    logic        busy;
    logic        capture_done;

    adc_capture_if s_if ();
    adc_capture_if m_if ();

    always #5 clk = ~clk;

    adc_capture #(.DEPTH_LOG2(DL)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .s_axis         (s_if),
        .m_axis         (m_if),
        .i_arm          (arm),
        .i_flush        (flush),
        .i_capture_len  (cap_len),
        .i_trigger_in   (trig),
        .o_busy         (busy),
        .o_capture_done (capture_done)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] mk(input int tag, input int k);
        logic [31:0] w;
        w = 32'(tag * 65536 + k);
        return {8{w}};
    endfunction

    // Reference model: beats the PS must receive, in order.
    typedef enum {M_IDLE, M_ARMED, M_CAP, M_DRAIN} mmode_t;
    mmode_t       m_mode = M_IDLE;
    int           m_len = 0;
    int           m_cnt = 0;
    logic         m_trig_prev = 1'b0;
    logic [255:0] exp_q[$];
    bit           prev_stall = 1'b0;
    logic [255:0] prev_data = '0;

    int           n_hs = 0;
    int           n_done = 0;
    int           n_tlast = 0;
    logic [255:0] first_data = '0;
    logic [255:0] last_data = '0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_mode      = M_IDLE;
                exp_q.delete();
                m_trig_prev = 1'b0;
                prev_stall  = 1'b0;
            end else begin
                if (flush) begin
                    m_mode     = M_IDLE;
                    exp_q.delete();
                    prev_stall = 1'b0;
                end else begin
                    case (m_mode)
                        M_IDLE: begin
                            if (arm) begin
                                m_len = (int'(cap_len) > DEPTH) ? DEPTH : int'(cap_len);
                                m_cnt = 0;
                                if (m_len != 0) m_mode = M_ARMED;
                            end
                        end
                        M_ARMED: if (trig && !m_trig_prev) m_mode = M_CAP;
                        M_CAP: begin
                            if (s_if.tvalid) begin
                                exp_q.push_back(s_if.tdata);
                                m_cnt++;
                                if (m_cnt == m_len) m_mode = M_DRAIN;
                            end
                        end
                        default: ;
                    endcase
                end
                m_trig_prev = trig;
            end
        end
    end

    // Per-cycle comparison on the falling edge, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            check("busy", busy, m_mode != M_IDLE);
            check("s_tready", s_if.tready, 1'b1);
            if (m_if.tvalid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_tvalid", m_if.tvalid, 1'b0);
                end else begin
                    if (prev_stall) check("stall_hold_tdata", m_if.tdata, prev_data);
`ifdef ADC_TLAST_EN
                    check("tlast", m_if.tlast, exp_q.size() == 1);
                    if (m_if.tready && m_if.tlast) n_tlast++;
`endif
                    if (m_if.tready) begin
                        check("tdata", m_if.tdata, exp_q[0]);
                        if (n_hs == 0) first_data = m_if.tdata;
                        last_data = m_if.tdata;
                        n_hs++;
                        void'(exp_q.pop_front());
                        check("capture_done", capture_done, exp_q.size() == 0);
                        if (capture_done) n_done++;
                        if (exp_q.size() == 0) m_mode = M_IDLE;
                    end else begin
                        check("capture_done_stalled", capture_done, 1'b0);
                    end
                end
            end else begin
                if (prev_stall) check("stall_tvalid_drop", m_if.tvalid, 1'b1);
                check("capture_done_novalid", capture_done, 1'b0);
            end
            prev_stall = m_if.tvalid && !m_if.tready;
            prev_data  = m_if.tdata;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        n_hs    = 0;
        n_done  = 0;
        n_tlast = 0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            cyc();
            n++;
        end
        check({name, "_idle_timeout"}, busy, 1'b0);
    endtask

    // Arm, one trigger edge carrying a junk beat that must be discarded, then nbeats beats.
    task automatic run_capture(input int tag, input int len, input int nbeats, input int k0);
        cap_len = (DL+1)'(len);
        arm = 1'b1;
        cyc();
        arm = 1'b0;
        trig = 1'b1;
        s_if.tvalid = 1'b1;
        s_if.tdata  = '1;
        cyc();
        trig = 1'b0;
        for (int k = 0; k < nbeats; k++) begin
            s_if.tdata = mk(tag, k0 + k);
            cyc();
        end
        s_if.tvalid = 1'b0;
    endtask

    initial begin
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        m_if.tready = 1'b1;
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_tvalid", m_if.tvalid, 1'b0);
        check("rst_tdata", m_if.tdata, '0);
        check("rst_done", capture_done, 1'b0);
        check("rst_tready", s_if.tready, 1'b1);
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();

        // 1: basic capture of 4 out of 6 beats
        clr();
        run_capture(1, 4, 6, 0);
        wait_idle("t1", 50);
        check("t1_handshakes", n_hs, 4);
        check("t1_done_pulses", n_done, 1);
        check("t1_first", first_data, {8{32'h0001_0000}});
        check("t1_last", last_data, {8{32'h0001_0003}});

        // 2: backpressure pattern 1,0,0 during drain
        clr();
        m_if.tready = 1'b0;
        run_capture(2, 4, 4, 0);
        for (int c = 0; c < 60 && busy; c++) begin
            m_if.tready = (c % 3 == 0);
            cyc();
        end
        m_if.tready = 1'b1;
        wait_idle("t2", 5);
        check("t2_handshakes", n_hs, 4);
        check("t2_done_pulses", n_done, 1);
        check("t2_last", last_data, {8{32'h0002_0003}});
`ifdef ADC_TLAST_EN
        check("t2_tlast_count", n_tlast, 1);
`endif

        // 3: trigger already high at arm is not an edge
        clr();
        trig = 1'b1;
        cyc();
        cap_len = 11'd3;
        arm = 1'b1;
        cyc();
        arm = 1'b0;
        s_if.tvalid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            s_if.tdata = mk(9, k);
            cyc();
        end
        s_if.tvalid = 1'b0;
        check("t3_still_armed", busy, 1'b1);
        check("t3_no_output", n_hs, 0);
        trig = 1'b0;
        cyc();
        trig = 1'b1;
        cyc();
        trig = 1'b0;
        s_if.tvalid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            s_if.tdata = mk(3, k);
            cyc();
        end
        s_if.tvalid = 1'b0;
        wait_idle("t3", 50);
        check("t3_handshakes", n_hs, 3);
        check("t3_first", first_data, {8{32'h0003_0000}});

        // 4: flush mid-capture, then simultaneous arm+flush, then fresh capture
        clr();
        cap_len = 11'd8;
        arm = 1'b1;
        cyc();
        arm = 1'b0;
        trig = 1'b1;
        cyc();
        trig = 1'b0;
        s_if.tvalid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            s_if.tdata = mk(8, k);
            cyc();
        end
        s_if.tvalid = 1'b0;
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        check("t4_flush_busy", busy, 1'b0);
        check("t4_flush_tvalid", m_if.tvalid, 1'b0);
        cap_len = 11'd3;
        arm = 1'b1;
        flush = 1'b1;
        cyc();
        arm = 1'b0;
        flush = 1'b0;
        check("t4_arm_flush_idle", busy, 1'b0);
        run_capture(4, 2, 2, 256);
        wait_idle("t4", 50);
        check("t4_handshakes", n_hs, 2);
        check("t4_first", first_data, {8{32'h0004_0100}});

        // 5: zero length stays idle, oversize length saturates to depth
        clr();
        cap_len = '0;
        arm = 1'b1;
        cyc();
        arm = 1'b0;
        check("t5_zero_idle", busy, 1'b0);
        trig = 1'b1;
        s_if.tvalid = 1'b1;
        s_if.tdata = mk(5, 7);
        cyc();
        cyc();
        trig = 1'b0;
        s_if.tvalid = 1'b0;
        cyc();
        check("t5_zero_no_output", n_hs, 0);
        run_capture(5, DEPTH + 5, DEPTH + 6, 0);
        wait_idle("t5", 3000);
        check("t5_handshakes", n_hs, DEPTH);
        check("t5_done_pulses", n_done, 1);
        check("t5_last", last_data, {8{32'h0005_03FF}});

        // 6: asynchronous reset during a stalled drain
        clr();
        m_if.tready = 1'b0;
        run_capture(6, 4, 4, 0);
        for (int c = 0; c < 10 && !m_if.tvalid; c++) cyc();
        check("t6_tvalid_seen", m_if.tvalid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_tvalid", m_if.tvalid, 1'b0);
        check("t6_rst_busy", busy, 1'b0);
        check("t6_rst_tdata", m_if.tdata, '0);
        check("t6_rst_done", capture_done, 1'b0);
        check("t6_rst_tready", s_if.tready, 1'b1);
        cyc();
        cyc();
        rst_n = 1'b1;
        m_if.tready = 1'b1;
        cyc();
        check("t6_post_tready", s_if.tready, 1'b1);
        check("t6_post_busy", busy, 1'b0);

        // 7: recovery with the minimum length
        clr();
        run_capture(7, 1, 2, 0);
        wait_idle("t7", 20);
        check("t7_handshakes", n_hs, 1);
        check("t7_first", first_data, {8{32'h0007_0000}});
        check("t7_done_pulses", n_done, 1);

        cyc();
        cyc();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
